lc3b_mem_responder: RTL and testbench



---
 rtl/lc3b_types.sv | 14 +
 rtl/lc3b_mem_responder_mem_array.sv | 30 +++
 rtl/lc3b_mem_responder.sv | 134 +++++++++++++
 tb/tb_lc3b_mem_responder.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b types: datapath word plus the memory-port responder
// state and byte-mask types.
package lc3b_types;

   typedef logic [15:0] lc3b_word;
   typedef logic [1:0]  lc3b_mem_wmask;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } lc3b_mem_state;

endpackage

// File: rtl/lc3b_mem_responder_mem_array.sv
// Word array behind the responder: synchronous byte-masked write,
// synchronous enabled read, no reset.
module mem_array
   import lc3b_types::*;
#(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  i_we,
   input  logic [1:0]            i_wmask,
   input  logic [ADDR_WIDTH-1:0] i_idx,
   input  logic [15:0]           i_wdata,
   input  logic                  i_re,
   output logic [15:0]           o_rdata
);

   lc3b_word r_mem [2**ADDR_WIDTH];
   lc3b_word r_q;

   always_ff @(posedge clk) begin
      if (i_we) begin
         if (i_wmask[0]) r_mem[i_idx][7:0]  <= i_wdata[7:0];
         if (i_wmask[1]) r_mem[i_idx][15:8] <= i_wdata[15:8];
      end
      if (i_re) r_q <= r_mem[i_idx];
   end

   assign o_rdata = r_q;

endmodule

// File: rtl/lc3b_mem_responder.sv
// Memory-port slave with fixed LATENCY and one-cycle resp pulse.
// Optional sticky protocol checker enabled by LC3B_MEM_ERRCHK_EN.
module lc3b_mem_responder
   import lc3b_types::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int LATENCY    = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        read_b,
   input  logic        write_b,
   input  logic [1:0]  wmask_b,
   input  logic [15:0] address_b,
   input  logic [15:0] wdata_b,
   output logic        resp_b,
   output logic [15:0] rdata_b,
   output logic        err
);

   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 2);

   lc3b_mem_state         r_state;
   logic [3:0]            r_cnt;
   logic                  r_wr;
   logic [ADDR_WIDTH-1:0] r_idx;
   lc3b_word              r_wdata;
   lc3b_mem_wmask         r_wmask;
   logic                  r_resp;
   logic                  r_rvalid;

   logic                  w_idle;
   logic                  w_req;
   logic                  w_fire;
   logic                  w_wr;
   logic [ADDR_WIDTH-1:0] w_idx;
   lc3b_word              w_wdata;
   lc3b_mem_wmask         w_wmask;
   lc3b_word              w_q;

   assign w_idle = (r_state == IDLE);
   assign w_req  = read_b | write_b;

   // With LATENCY=1 the access happens on the capture edge itself,
   // so the array is fed straight from the port while idle.
   assign w_fire  = (w_idle && w_req && (LATENCY == 1)) ||
                    ((r_state == BUSY) && (r_cnt == 4'd0));
   assign w_wr    = w_idle ? write_b : r_wr;
   assign w_idx   = w_idle ? address_b[ADDR_WIDTH:1] : r_idx;
   assign w_wdata = w_idle ? wdata_b : r_wdata;
   assign w_wmask = w_idle ? wmask_b : r_wmask;

   mem_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_mem (
      .clk     (clk),
      .i_we    (w_fire & w_wr),
      .i_wmask (w_wmask),
      .i_idx   (w_idx),
      .i_wdata (w_wdata),
      .i_re    (w_fire & ~w_wr),
      .o_rdata (w_q)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_wr     <= 1'b0;
         r_idx    <= '0;
         r_wdata  <= '0;
         r_wmask  <= '0;
         r_resp   <= 1'b0;
         r_rvalid <= 1'b0;
      end else begin
         r_resp <= w_fire;
         if (w_fire && !w_wr) r_rvalid <= 1'b1;
         case (r_state)
            IDLE: begin
               if (w_req) begin
                  r_wr    <= write_b;
                  r_idx   <= address_b[ADDR_WIDTH:1];
                  r_wdata <= wdata_b;
                  r_wmask <= wmask_b;
                  if (LATENCY == 1) begin
                     r_state <= RESP;
                  end else begin
                     r_state <= BUSY;
                     r_cnt   <= CNT_INIT;
                  end
               end
            end
            BUSY: begin
               if (r_cnt == 4'd0) r_state <= RESP;
               else               r_cnt   <= r_cnt - 4'd1;
            end
            RESP:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   // Array read register has no reset; mask it until a read completes.
   assign resp_b  = r_resp;
   assign rdata_b = r_rvalid ? w_q : 16'h0000;

`ifdef LC3B_MEM_ERRCHK_EN
   logic        r_err;
   logic        r_rd;
   logic [15:0] r_addr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err  <= 1'b0;
         r_rd   <= 1'b0;
         r_addr <= '0;
      end else begin
         if (w_idle && w_req) begin
            r_rd   <= read_b;
            r_addr <= address_b;
            if (read_b && write_b) r_err <= 1'b1;
         end
         if ((r_state == BUSY) &&
             ((read_b != r_rd) || (write_b != r_wr) ||
              (address_b != r_addr) || (wdata_b != r_wdata) ||
              (wmask_b != r_wmask)))
            r_err <= 1'b1;
      end
   end

   assign err = r_err;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Directed bench: dut0 uses LATENCY=3, dut1 uses LATENCY=1.
// Table of single transactions plus hand-written multi-cycle sequences.
module tb_lc3b_mem_responder;

`ifdef LC3B_MEM_ERRCHK_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic        rd    [2];
   logic        wr    [2];
   logic [1:0]  wm    [2];
   logic [15:0] addr  [2];
   logic [15:0] wd    [2];
   logic        resp  [2];
   logic [15:0] rdata [2];
   logic        err   [2];

   int n_pass;
   int n_total;

   lc3b_mem_responder #(.ADDR_WIDTH(10), .LATENCY(3)) dut0 (
      .clk(clk), .rst_n(rst_n), .read_b(rd[0]), .write_b(wr[0]),
      .wmask_b(wm[0]), .address_b(addr[0]), .wdata_b(wd[0]),
      .resp_b(resp[0]), .rdata_b(rdata[0]), .err(err[0])
   );

   lc3b_mem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .read_b(rd[1]), .write_b(wr[1]),
      .wmask_b(wm[1]), .address_b(addr[1]), .wdata_b(wd[1]),
      .resp_b(resp[1]), .rdata_b(rdata[1]), .err(err[1])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      int          d;
      logic        r;
      logic        w;
      logic [15:0] a;
      logic [15:0] wdat;
      logic [1:0]  m;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs [11];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic idle_inputs();
      for (int i = 0; i < 2; i++) begin
         rd[i] = 1'b0; wr[i] = 1'b0; wm[i] = 2'b00;
         addr[i] = 16'h0; wd[i] = 16'h0;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Called just after a negedge; returns just after a negedge.
   task automatic do_op(input int d, input logic r, input logic w,
                        input logic [15:0] a, input logic [15:0] wdat,
                        input logic [1:0] m, input logic [15:0] exp,
                        input string tag);
      int n;
      int lat;
      lat = (d == 0) ? 3 : 1;
      rd[d] = r; wr[d] = w; addr[d] = a; wd[d] = wdat; wm[d] = m;
      n = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (resp[d]) begin
            n = i;
            break;
         end
      end
      check({tag, " latency"}, n, lat);
      check({tag, " rdata"}, rdata[d], exp);
      rd[d] = 1'b0; wr[d] = 1'b0;
      @(negedge clk);
      check({tag, " pulse"}, resp[d], 1'b0);
      check({tag, " rdata hold"}, rdata[d], exp);
   endtask

   initial begin
      int pulses;
      int first_at;
      int second_at;
      logic [15:0] r1;
      logic [15:0] r2;

      n_pass = 0;
      n_total = 0;
      idle_inputs();
      rst_n = 1'b0;

      vecs[0]  = '{0, 1'b0, 1'b1, 16'h0040, 16'hBEEF, 2'b11, 16'h0000};
      vecs[1]  = '{0, 1'b1, 1'b0, 16'h0040, 16'h0000, 2'b00, 16'hBEEF};
      vecs[2]  = '{0, 1'b0, 1'b1, 16'h0040, 16'h12AB, 2'b01, 16'hBEEF};
      vecs[3]  = '{0, 1'b1, 1'b0, 16'h0040, 16'h0000, 2'b00, 16'hBEAB};
      vecs[4]  = '{0, 1'b0, 1'b1, 16'h0040, 16'h34CD, 2'b10, 16'hBEAB};
      vecs[5]  = '{0, 1'b1, 1'b0, 16'h0040, 16'h0000, 2'b11, 16'h34AB};
      vecs[6]  = '{0, 1'b0, 1'b1, 16'h0042, 16'h9999, 2'b11, 16'h34AB};
      vecs[7]  = '{1, 1'b0, 1'b1, 16'h0801, 16'hA5A5, 2'b11, 16'h0000};
      vecs[8]  = '{1, 1'b1, 1'b0, 16'h0000, 16'h0000, 2'b00, 16'hA5A5};
      vecs[9]  = '{1, 1'b0, 1'b1, 16'h0000, 16'hFFFF, 2'b00, 16'hA5A5};
      vecs[10] = '{1, 1'b1, 1'b0, 16'h0800, 16'h0000, 2'b00, 16'hA5A5};

      repeat (2) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("rst resp%0d", i), resp[i], 1'b0);
         check($sformatf("rst rdata%0d", i), rdata[i], 16'h0);
         check($sformatf("rst err%0d", i), err[i], 1'b0);
      end
      rst_n = 1'b1;
      @(negedge clk);

      foreach (vecs[i])
         do_op(vecs[i].d, vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].wdat,
               vecs[i].m, vecs[i].exp, $sformatf("vec%0d", i));

      // Back-to-back reads with read_b held through the RESP edge.
      rd[0] = 1'b1; addr[0] = 16'h0040;
      pulses = 0; first_at = 0; second_at = 0; r1 = '0; r2 = '0;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (resp[0]) begin
            pulses++;
            if (pulses == 1) begin first_at = i; r1 = rdata[0]; end
            if (pulses == 2) begin second_at = i; r2 = rdata[0]; end
         end
         if (i == 4) addr[0] = 16'h0042;
         if (i == 7) rd[0] = 1'b0;
      end
      check("b2b pulses", pulses, 2);
      check("b2b first at", first_at, 3);
      check("b2b second at", second_at, 7);
      check("b2b rdata1", r1, 16'h34AB);
      check("b2b rdata2", r2, 16'h9999);

      // Reset during BUSY drops the write.
      do_op(0, 1'b0, 1'b1, 16'h0010, 16'h1111, 2'b11, 16'h9999, "pre");
      wr[0] = 1'b1; addr[0] = 16'h0010; wd[0] = 16'h5555; wm[0] = 2'b11;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst rdata", rdata[0], 16'h0);
      pulses = 0;
      repeat (2) begin
         @(negedge clk);
         if (resp[0]) pulses++;
      end
      wr[0] = 1'b0;
      rst_n = 1'b1;
      repeat (5) begin
         @(negedge clk);
         if (resp[0]) pulses++;
      end
      check("midrst no resp", pulses, 0);
      check("midrst rdata after", rdata[0], 16'h0);
      do_op(0, 1'b1, 1'b0, 16'h0010, 16'h0, 2'b00, 16'h1111, "midrst rd");

      // Simultaneous read and write behaves as a write.
      do_op(0, 1'b1, 1'b1, 16'h0060, 16'h4242, 2'b11, 16'h1111, "rw");
      check("rw err", err[0], ERR_EN);
      do_op(0, 1'b1, 1'b0, 16'h0060, 16'h0, 2'b00, 16'h4242, "rw rd");
      check("rw err sticky", err[0], ERR_EN);
      do_reset();
      check("err cleared", err[0], 1'b0);

      // Address change during BUSY: captured request still serviced.
      rd[0] = 1'b1; addr[0] = 16'h0040;
      @(negedge clk);
      addr[0] = 16'h0044;
      first_at = 0;
      for (int i = 2; i <= 20; i++) begin
         @(negedge clk);
         if (resp[0]) begin
            first_at = i;
            break;
         end
      end
      check("chg latency", first_at, 3);
      check("chg rdata", rdata[0], 16'h34AB);
      rd[0] = 1'b0;
      repeat (4) @(negedge clk);
      check("chg err", err[0], ERR_EN);
      check("dut1 err", err[1], 1'b0);
      do_reset();
      check("chg err cleared", err[0], 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
